slt_compare_unit: RTL and testbench

//  Iterative subtract-and-compare stage that sits directly upstream of the set-less-than

---
 rtl/slt_compare_unit_if.sv | 28 ++
 rtl/slt_compare_unit.sv | 111 +++++++++++
 tb/tb_slt_compare_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/slt_compare_unit_if.sv
// Request/response bundle for the iterative subtract-and-compare unit.
`timescale 1ns/1ps
interface slt_compare_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             lt_out;
  logic [WIDTH-1:0] diff_out;
  logic             zero_out;

  // Requester / result consumer side
  modport master (
    output in_valid, a_in, b_in, is_signed, out_ready,
    input  in_ready, out_valid, lt_out, diff_out, zero_out
  );

  // Compare unit side
  modport slave (
    input  in_valid, a_in, b_in, is_signed, out_ready,
    output in_ready, out_valid, lt_out, diff_out, zero_out
  );
endinterface

// File: rtl/slt_compare_unit.sv
// Iterative A-B, CHUNK bits per cycle LSB first, producing the set-less-than bit,
// the difference and a zero flag for the downstream SLT zero-extend stage.
`timescale 1ns/1ps
module slt_compare_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  slt_compare_unit_if.slave  bus
);

  localparam int unsigned NSTEP  = WIDTH / CHUNK;
  localparam int unsigned STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int unsigned SUM_W  = CHUNK + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  diff_q;
  logic              a_msb;
  logic              b_msb;
  logic              sgn_q;
  logic              carry_q;
  logic [STEP_W-1:0] step_q;
  logic              valid_q;
  logic              lt_q;
  logic              zero_q;

  logic [SUM_W-1:0]  sum_c;
  logic [WIDTH-1:0]  diff_next_c;
  logic              ovf_c;
  logic              lt_next_c;
  logic              last_c;

  // One chunk of A + ~B + carry; operands shift right so the live chunk is always at bit 0,
  // and the difference fills in from the top so it is aligned after NSTEP steps.
  always_comb begin
    sum_c       = {1'b0, a_q[CHUNK-1:0]} + {1'b0, ~b_q[CHUNK-1:0]} + SUM_W'(carry_q);
    diff_next_c = (diff_q >> CHUNK) | (WIDTH'(sum_c[CHUNK-1:0]) << (WIDTH - CHUNK));
    ovf_c       = (a_msb != b_msb) && (diff_next_c[WIDTH-1] != a_msb);
    lt_next_c   = sgn_q ? (diff_next_c[WIDTH-1] ^ ovf_c) : ~sum_c[CHUNK];
    last_c      = (step_q == STEP_W'(NSTEP - 1));
  end

  // Control FSM and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      sgn_q   <= 1'b0;
      carry_q <= 1'b0;
      step_q  <= '0;
      valid_q <= 1'b0;
      lt_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            a_msb   <= bus.a_in[WIDTH-1];
            b_msb   <= bus.b_in[WIDTH-1];
            sgn_q   <= bus.is_signed;
            carry_q <= 1'b1;
            step_q  <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          diff_q  <= diff_next_c;
          carry_q <= sum_c[CHUNK];
          step_q  <= step_q + 1'b1;
          if (last_c) begin
            lt_q    <= lt_next_c;
            zero_q  <= ~|diff_next_c;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = valid_q;
  assign bus.lt_out    = lt_q;
  assign bus.diff_out  = diff_q;
  assign bus.zero_out  = zero_q;

endmodule

// File: tb/tb_slt_compare_unit.sv
// Scoreboard bench for slt_compare_unit: driver pushes model results, monitor pops on handshake.
`timescale 1ns/1ps
module tb_slt_compare_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned NSTEP = WIDTH / CHUNK;
  localparam int          BOUND = 200;

  typedef struct {
    logic             lt;
    logic [WIDTH-1:0] diff;
    logic             zero;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  int   cyc;
  logic rnd_rdy;
  logic prev_v;

  exp_t exp_q[$];
  int   acc_q[$];

  slt_compare_unit_if #(.WIDTH(WIDTH)) bus ();

  slt_compare_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain arithmetic comparison of the two operands
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s);
    exp_t e;
    e.diff = a - b;
    e.lt   = s ? ($signed(a) < $signed(b)) : (a < b);
    e.zero = (a == b);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound of %0d cycles expired (t=%0t)", name, BOUND, $time);
  endtask

  // Offer one request and hold it until accepted; optionally stall the consumer randomly
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    while (!ok && n <= BOUND) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
      end else begin
        n++;
        @(posedge clk);
        #1;
        if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!ok) begin
      fail_bound("accept");
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      exp_q.push_back(model(a, b, s));
      acc_q.push_back(cyc);
      bus.in_valid = 1'b0;
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Wait until every expected result has been retired
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n <= BOUND) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_bound("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic send_wait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic s);
    send(a, b, s);
    drain();
  endtask

  // Monitor: latency on out_valid rise, result contents on every retire handshake
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (bus.out_valid && !prev_v) begin
        if (acc_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL spurious_valid: out_valid rose with no request outstanding");
        end else begin
          a = acc_q.pop_front();
          check("latency", 64'(cyc - a), 64'(NSTEP));
        end
      end
      prev_v = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL extra_result: diff_out=0x%0h with empty scoreboard", bus.diff_out);
        end else begin
          e = exp_q.pop_front();
          check("lt_out",   64'(bus.lt_out),   64'(e.lt));
          check("diff_out", 64'(bus.diff_out), 64'(e.diff));
          check("zero_out", 64'(bus.zero_out), 64'(e.zero));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    n_vec         = 0;
    n_bad         = 0;
    cyc           = 0;
    rnd_rdy       = 1'b0;
    prev_v        = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_lt",        64'(bus.lt_out),    64'd0);
    check("rst_diff",      64'(bus.diff_out),  64'd0);
    check("rst_zero",      64'(bus.zero_out),  64'd0);
    @(posedge clk);
    #1;

    // Directed vectors
    send_wait(32'd5,          32'd7, 1'b0);
    send_wait(32'h8000_0000,  32'd1, 1'b1);
    send_wait(32'h8000_0000,  32'd1, 1'b0);
    send_wait(32'h0000_1234,  32'h0000_1234, 1'b1);
    send_wait(32'hFFFF_FFFF,  32'd0, 1'b1);
    send_wait(32'hFFFF_FFFF,  32'd0, 1'b0);
    send_wait(32'h7FFF_FFFF,  32'hFFFF_FFFF, 1'b1);

    // Backpressure in DONE with a competing request on the inputs
    bus.out_ready = 1'b0;
    send(32'hDEAD_BEEF, 32'h0000_BEEF, 1'b1);
    e = exp_q[0];
    n = 0;
    while (!bus.out_valid && n <= BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) fail_bound("bp_valid");
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.a_in      = $urandom;
    bus.b_in      = $urandom;
    bus.is_signed = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready",  64'(bus.in_ready),  64'd0);
      check("bp_diff",      64'(bus.diff_out),  64'(e.diff));
      check("bp_lt",        64'(bus.lt_out),    64'(e.lt));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (NSTEP + 2) @(negedge clk);
    check("bp_no_latch", 64'(bus.out_valid), 64'd0);
    check("bp_queue",    64'(exp_q.size()),  64'd0);
    @(posedge clk);
    #1;

    // Reset while RUN is at step 3
    send(32'h1234_5678, 32'd1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("run_in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_diff",      64'(bus.diff_out),  64'd0);
    check("abort_in_ready",  64'(bus.in_ready),  64'd1);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_wait(32'd9, 32'd2, 1'b0);

    // Back-to-back random requests with random consumer stalls
    rnd_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
        2:       rb = {~ra[WIDTH-1], ra[WIDTH-2:0]};
        default: rb = $urandom;
      endcase
      send(ra, rb, 1'($urandom_range(0, 1)));
    end
    rnd_rdy       = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    check("final_queue", 64'(exp_q.size()), 64'd0);
    check("final_acc",   64'(acc_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
